// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: in-order commit, CDB capture,
// operand-forwarding lookups and squash on a committed mispredict.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              alloc_valid_in,
    input  logic [4:0]        alloc_rd_in,
    input  logic              alloc_writes_rd_in,
    input  logic              alloc_is_branch_in,
    output logic              alloc_ready_out,
    output logic [2:0]        alloc_ix_out,
    input  logic              cdb_valid_in,
    input  logic [2:0]        cdb_ix_in,
    input  logic [DATA_W-1:0] cdb_data_in,
    input  logic              cdb_mispredict_in,
    input  logic [2:0]        query_ix1_in,
    input  logic [2:0]        query_ix2_in,
    output logic              query_done1_out,
    output logic              query_done2_out,
    output logic [DATA_W-1:0] query_data1_out,
    output logic [DATA_W-1:0] query_data2_out,
    output logic              commit_we_out,
    output logic [4:0]        commit_wa_out,
    output logic [DATA_W-1:0] commit_wd_out,
    output logic [2:0]        commit_ix_out,
    output logic              flush_out,
    output logic [4:0]        flush_addrs_out [7:0],
    output logic [3:0]        count_out,
    output logic              empty_out
);

    logic              valid_q [7:0];
    logic              done_q  [7:0];
    logic [4:0]        rd_q    [7:0];
    logic              wr_q    [7:0];
    logic              br_q    [7:0];
    logic              misp_q  [7:0];
    logic [DATA_W-1:0] data_q  [7:0];

    logic [2:0] head_q;
    logic [2:0] tail_q;
    logic [3:0] count_q;
    logic       flush_q;
    logic [4:0] flush_addrs_q [7:0];

    logic commit_fire;
    logic flush_go;
    logic alloc_fire;
    logic cdb_hit;

    assign commit_fire = valid_q[head_q] && done_q[head_q] && !flush_q;
    assign flush_go    = commit_fire && misp_q[head_q];
    assign cdb_hit     = cdb_valid_in && valid_q[cdb_ix_in];

    // No bypass of a freeing commit: a full buffer stays full this cycle.
    assign alloc_ready_out = (count_q < 4'(DEPTH)) && !flush_q && !flush_go;
    assign alloc_fire      = alloc_valid_in && alloc_ready_out;
    assign alloc_ix_out    = tail_q;

    assign commit_we_out = commit_fire && wr_q[head_q] && (rd_q[head_q] != 5'd0);
    assign commit_wa_out = rd_q[head_q];
    assign commit_wd_out = data_q[head_q];
    assign commit_ix_out = head_q;

    assign flush_out       = flush_q;
    assign flush_addrs_out = flush_addrs_q;
    assign count_out       = count_q;
    assign empty_out       = (count_q == 4'd0);

    always_comb begin
        query_done1_out = valid_q[query_ix1_in] && done_q[query_ix1_in];
        query_data1_out = data_q[query_ix1_in];
        if (cdb_valid_in && cdb_ix_in == query_ix1_in && valid_q[query_ix1_in]) begin
            query_done1_out = 1'b1;
            query_data1_out = cdb_data_in;
        end
    end

    always_comb begin
        query_done2_out = valid_q[query_ix2_in] && done_q[query_ix2_in];
        query_data2_out = data_q[query_ix2_in];
        if (cdb_valid_in && cdb_ix_in == query_ix2_in && valid_q[query_ix2_in]) begin
            query_done2_out = 1'b1;
            query_data2_out = cdb_data_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flush_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]       <= 1'b0;
                done_q[i]        <= 1'b0;
                flush_addrs_q[i] <= '0;
            end
        end else begin
            flush_q <= flush_go;
            if (flush_go) begin
                // Snapshot the younger entries' destinations, then empty the buffer.
                for (int i = 0; i < DEPTH; i++) begin
                    flush_addrs_q[i] <= (valid_q[i] && 3'(i) != head_q && wr_q[i])
                                        ? rd_q[i] : 5'd0;
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (cdb_hit) begin
                    done_q[cdb_ix_in] <= 1'b1;
                    data_q[cdb_ix_in] <= cdb_data_in;
                    misp_q[cdb_ix_in] <= cdb_mispredict_in && br_q[cdb_ix_in];
                end
                if (commit_fire) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + 3'd1;
                end
                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    misp_q[tail_q]  <= 1'b0;
                    rd_q[tail_q]    <= alloc_rd_in;
                    wr_q[tail_q]    <= alloc_writes_rd_in;
                    br_q[tail_q]    <= alloc_is_branch_in;
                    tail_q          <= tail_q + 3'd1;
                end
                count_q <= count_q + 4'(alloc_fire) - 4'(commit_fire);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_reorder_buffer;

    logic        clk;
    logic        rst_n_in;
    logic        alloc_valid_in;
    logic [4:0]  alloc_rd_in;
    logic        alloc_writes_rd_in;
    logic        alloc_is_branch_in;
    logic        alloc_ready_out;
    logic [2:0]  alloc_ix_out;
    logic        cdb_valid_in;
    logic [2:0]  cdb_ix_in;
    logic [31:0] cdb_data_in;
    logic        cdb_mispredict_in;
    logic [2:0]  query_ix1_in;
    logic [2:0]  query_ix2_in;
    logic        query_done1_out;
    logic        query_done2_out;
    logic [31:0] query_data1_out;
    logic [31:0] query_data2_out;
    logic        commit_we_out;
    logic [4:0]  commit_wa_out;
    logic [31:0] commit_wd_out;
    logic [2:0]  commit_ix_out;
    logic        flush_out;
    logic [4:0]  flush_addrs_out [7:0];
    logic [3:0]  count_out;
    logic        empty_out;

    reorder_buffer dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n_in),
        .alloc_valid_in     (alloc_valid_in),
        .alloc_rd_in        (alloc_rd_in),
        .alloc_writes_rd_in (alloc_writes_rd_in),
        .alloc_is_branch_in (alloc_is_branch_in),
        .alloc_ready_out    (alloc_ready_out),
        .alloc_ix_out       (alloc_ix_out),
        .cdb_valid_in       (cdb_valid_in),
        .cdb_ix_in          (cdb_ix_in),
        .cdb_data_in        (cdb_data_in),
        .cdb_mispredict_in  (cdb_mispredict_in),
        .query_ix1_in       (query_ix1_in),
        .query_ix2_in       (query_ix2_in),
        .query_done1_out    (query_done1_out),
        .query_done2_out    (query_done2_out),
        .query_data1_out    (query_data1_out),
        .query_data2_out    (query_data2_out),
        .commit_we_out      (commit_we_out),
        .commit_wa_out      (commit_wa_out),
        .commit_wd_out      (commit_wd_out),
        .commit_ix_out      (commit_ix_out),
        .flush_out          (flush_out),
        .flush_addrs_out    (flush_addrs_out),
        .count_out          (count_out),
        .empty_out          (empty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input int av, input int rd, input int wr, input int br,
                          input int cv, input int cix, input int cd, input int cm,
                          input int q);
        rst_n_in           = 1'b1;
        alloc_valid_in     = 1'(av);
        alloc_rd_in        = 5'(rd);
        alloc_writes_rd_in = 1'(wr);
        alloc_is_branch_in = 1'(br);
        cdb_valid_in       = 1'(cv);
        cdb_ix_in          = 3'(cix);
        cdb_data_in        = 32'(cd);
        cdb_mispredict_in  = 1'(cm);
        query_ix1_in       = 3'(q);
        query_ix2_in       = 3'(q);
    endtask

    // Drive a cycle's inputs at the falling edge and let outputs settle.
    task automatic nx(input int av, input int rd, input int wr, input int br,
                      input int cv, input int cix, input int cd, input int cm,
                      input int q);
        @(negedge clk);
        set_in(av, rd, wr, br, cv, cix, cd, cm, q);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
    endtask

    typedef struct {
        int chk, rst, av, rd, wr, br, cv, cix, cd, cm, q;
        int rdy, aix, we, wa, wd, cixe, cnt, qd, qdat;
    } vec_t;

    vec_t vt [21];

    // Reference model: in-flight entries in program order.
    typedef struct {
        logic [2:0]  ix;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic        done;
        logic        misp;
        logic [31:0] data;
    } ment_t;

    ment_t      mq [$];
    int         mhead;
    bit         mflush;
    logic [4:0] mfa [8];

    task automatic mq_lookup(input logic [2:0] ix, output bit d, output logic [31:0] v);
        int k;
        k = -1;
        foreach (mq[i]) if (mq[i].ix == ix) k = i;
        d = 1'b0;
        v = '0;
        if (k >= 0 && cdb_valid_in && cdb_ix_in == ix) begin
            d = 1'b1;
            v = cdb_data_in;
        end else if (k >= 0 && mq[k].done) begin
            d = 1'b1;
            v = mq[k].data;
        end
    endtask

    task automatic model_step();
        int    sz;
        bit    fire, fl, rdy, d;
        int    aix;
        logic [31:0] v;
        ment_t e;
        sz   = mq.size();
        fire = sz > 0 && mq[0].done && !mflush;
        fl   = fire && mq[0].misp;
        rdy  = sz < 8 && !mflush && !fl;
        aix  = (mhead + sz) % 8;
        chk("r_ready", 32'(alloc_ready_out), 32'(rdy));
        chk("r_aix", 32'(alloc_ix_out), 32'(aix));
        chk("r_count", 32'(count_out), 32'(sz));
        chk("r_empty", 32'(empty_out), 32'(sz == 0));
        chk("r_cix", 32'(commit_ix_out), 32'(mhead));
        chk("r_we", 32'(commit_we_out), 32'(fire && mq[0].wr && mq[0].rd != 0));
        if (fire) begin
            chk("r_wa", 32'(commit_wa_out), 32'(mq[0].rd));
            chk("r_wd", commit_wd_out, mq[0].data);
        end
        chk("r_flush", 32'(flush_out), 32'(mflush));
        if (mflush)
            for (int j = 0; j < 8; j++)
                chk($sformatf("r_faddr%0d", j), 32'(flush_addrs_out[j]), 32'(mfa[j]));
        mq_lookup(query_ix1_in, d, v);
        chk("r_qd1", 32'(query_done1_out), 32'(d));
        if (d) chk("r_qv1", query_data1_out, v);
        mq_lookup(query_ix2_in, d, v);
        chk("r_qd2", 32'(query_done2_out), 32'(d));
        if (d) chk("r_qv2", query_data2_out, v);

        if (mflush) begin
            mflush = 1'b0;
            return;
        end
        if (cdb_valid_in)
            foreach (mq[i])
                if (mq[i].ix == cdb_ix_in) begin
                    e      = mq[i];
                    e.done = 1'b1;
                    e.data = cdb_data_in;
                    e.misp = cdb_mispredict_in && e.br;
                    mq[i]  = e;
                end
        if (fl) begin
            for (int j = 0; j < 8; j++) mfa[j] = '0;
            for (int i = 1; i < sz; i++)
                if (mq[i].wr) mfa[mq[i].ix] = mq[i].rd;
            mq.delete();
            mhead  = 0;
            mflush = 1'b1;
            return;
        end
        if (fire) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % 8;
        end
        if (alloc_valid_in && rdy) begin
            e.ix   = 3'(aix);
            e.rd   = alloc_rd_in;
            e.wr   = alloc_writes_rd_in;
            e.br   = alloc_is_branch_in;
            e.done = 1'b0;
            e.misp = 1'b0;
            e.data = '0;
            mq.push_back(e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [4:0] efa [8];

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n_in = 1'b0;

        // chk rst av rd wr br cv cix cd cm q | rdy aix we wa wd cix cnt qd qdat
        vt[0]  = '{0,0,1, 1,1,0, 0,0,0,    0,0, 0,0,0, 0,0,    0,0,0,0};
        vt[1]  = '{0,0,1, 1,1,0, 0,0,0,    0,0, 0,0,0, 0,0,    0,0,0,0};
        vt[2]  = '{1,1,0, 0,0,0, 0,0,0,    0,0, 1,0,0, 0,0,    0,0,0,0};
        vt[3]  = '{1,1,1, 5,1,0, 0,0,0,    0,0, 1,0,0, 0,0,    0,0,0,0};
        vt[4]  = '{1,1,1, 6,1,0, 0,0,0,    0,0, 1,1,0, 0,0,    0,1,0,0};
        vt[5]  = '{1,1,0, 0,0,0, 1,1,'hB,  0,1, 1,2,0, 0,0,    0,2,1,'hB};
        vt[6]  = '{1,1,0, 0,0,0, 1,0,'hA,  0,0, 1,2,0, 0,0,    0,2,1,'hA};
        vt[7]  = '{1,1,0, 0,0,0, 0,0,0,    0,1, 1,2,1, 5,'hA,  0,2,1,'hB};
        vt[8]  = '{1,1,0, 0,0,0, 0,0,0,    0,0, 1,2,1, 6,'hB,  1,1,0,0};
        vt[9]  = '{1,1,1, 0,1,0, 0,0,0,    0,0, 1,2,0, 0,0,    2,0,0,0};
        vt[10] = '{1,1,1, 9,0,0, 0,0,0,    0,0, 1,3,0, 0,0,    2,1,0,0};
        vt[11] = '{1,1,0, 0,0,0, 1,2,'h11, 0,2, 1,4,0, 0,0,    2,2,1,'h11};
        vt[12] = '{1,1,0, 0,0,0, 1,3,'h22, 0,3, 1,4,0, 0,0,    2,2,1,'h22};
        vt[13] = '{1,1,0, 0,0,0, 0,0,0,    0,2, 1,4,0, 0,0,    3,1,0,0};
        vt[14] = '{1,1,0, 0,0,0, 0,0,0,    0,3, 1,4,0, 0,0,    4,0,0,0};
        vt[15] = '{1,1,1,12,1,0, 0,0,0,    0,0, 1,4,0, 0,0,    4,0,0,0};
        vt[16] = '{1,1,0, 0,0,0, 0,0,0,    0,4, 1,5,0, 0,0,    4,1,0,0};
        vt[17] = '{1,1,0, 0,0,0, 1,4,'h55, 0,4, 1,5,0, 0,0,    4,1,1,'h55};
        vt[18] = '{1,1,0, 0,0,0, 0,0,0,    0,4, 1,5,1,12,'h55, 4,1,1,'h55};
        vt[19] = '{1,1,0, 0,0,0, 1,6,'h77, 0,6, 1,5,0, 0,0,    5,0,0,0};
        vt[20] = '{1,1,0, 0,0,0, 0,0,0,    0,6, 1,5,0, 0,0,    5,0,0,0};

        foreach (vt[r]) begin
            @(negedge clk);
            set_in(vt[r].av, vt[r].rd, vt[r].wr, vt[r].br, vt[r].cv,
                   vt[r].cix, vt[r].cd, vt[r].cm, vt[r].q);
            rst_n_in = 1'(vt[r].rst);
            #1;
            if (vt[r].chk != 0) begin
                chk($sformatf("v%0d_ready", r), 32'(alloc_ready_out), 32'(vt[r].rdy));
                chk($sformatf("v%0d_aix", r), 32'(alloc_ix_out), 32'(vt[r].aix));
                chk($sformatf("v%0d_we", r), 32'(commit_we_out), 32'(vt[r].we));
                if (vt[r].we != 0) begin
                    chk($sformatf("v%0d_wa", r), 32'(commit_wa_out), 32'(vt[r].wa));
                    chk($sformatf("v%0d_wd", r), commit_wd_out, 32'(vt[r].wd));
                end
                chk($sformatf("v%0d_cix", r), 32'(commit_ix_out), 32'(vt[r].cixe));
                chk($sformatf("v%0d_count", r), 32'(count_out), 32'(vt[r].cnt));
                chk($sformatf("v%0d_empty", r), 32'(empty_out), 32'(vt[r].cnt == 0));
                chk($sformatf("v%0d_flush", r), 32'(flush_out), 32'd0);
                chk($sformatf("v%0d_qd1", r), 32'(query_done1_out), 32'(vt[r].qd));
                chk($sformatf("v%0d_qd2", r), 32'(query_done2_out), 32'(vt[r].qd));
                if (vt[r].qd != 0) begin
                    chk($sformatf("v%0d_qv1", r), query_data1_out, 32'(vt[r].qdat));
                    chk($sformatf("v%0d_qv2", r), query_data2_out, 32'(vt[r].qdat));
                end
            end
        end

        // Mispredicted jump at ix0 with younger rd=3 and rd=7.
        do_reset();
        nx(1, 1, 1, 1, 0, 0, 0, 0, 0);
        chk("mp_aix0", 32'(alloc_ix_out), 32'd0);
        nx(1, 3, 1, 0, 0, 0, 0, 0, 0);
        nx(1, 7, 1, 0, 0, 0, 0, 0, 0);
        nx(0, 0, 0, 0, 1, 0, 'h100, 1, 0);
        chk("mp_qd", 32'(query_done1_out), 32'd1);
        nx(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mp_link_we", 32'(commit_we_out), 32'd1);
        chk("mp_link_wa", 32'(commit_wa_out), 32'd1);
        chk("mp_link_wd", commit_wd_out, 32'h100);
        chk("mp_c_ready", 32'(alloc_ready_out), 32'd0);
        chk("mp_c_flush", 32'(flush_out), 32'd0);
        nx(1, 9, 1, 0, 1, 1, 5, 0, 1);
        efa = '{5'd0, 5'd3, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        chk("mp_flush", 32'(flush_out), 32'd1);
        chk("mp_f_we", 32'(commit_we_out), 32'd0);
        chk("mp_f_ready", 32'(alloc_ready_out), 32'd0);
        chk("mp_f_count", 32'(count_out), 32'd0);
        chk("mp_f_qd", 32'(query_done1_out), 32'd0);
        for (int j = 0; j < 8; j++)
            chk($sformatf("mp_faddr%0d", j), 32'(flush_addrs_out[j]), 32'(efa[j]));
        nx(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("mp_after_flush", 32'(flush_out), 32'd0);
        chk("mp_after_count", 32'(count_out), 32'd0);
        chk("mp_after_aix", 32'(alloc_ix_out), 32'd0);
        chk("mp_after_ready", 32'(alloc_ready_out), 32'd1);
        chk("mp_after_qd", 32'(query_done1_out), 32'd0);

        // Reset on the edge that would raise a flush discards it.
        do_reset();
        nx(1, 0, 0, 1, 0, 0, 0, 0, 0);
        nx(1, 4, 1, 0, 0, 0, 0, 0, 0);
        nx(0, 0, 0, 0, 1, 0, 1, 1, 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n_in = 1'b0;
        nx(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_ready", 32'(alloc_ready_out), 32'd1);
        chk("rst_aix", 32'(alloc_ix_out), 32'd0);

        // Fill, stall when full, free one entry, wrap the tail.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            nx(1, i + 1, 1, 0, 0, 0, 0, 0, 0);
            chk($sformatf("full_aix%0d", i), 32'(alloc_ix_out), 32'(i));
        end
        nx(1, 20, 1, 0, 0, 0, 0, 0, 0);
        chk("full_ready", 32'(alloc_ready_out), 32'd0);
        chk("full_count", 32'(count_out), 32'd8);
        chk("full_aix", 32'(alloc_ix_out), 32'd0);
        nx(1, 20, 1, 0, 1, 0, 'hAA, 0, 0);
        chk("full_cdb_ready", 32'(alloc_ready_out), 32'd0);
        nx(1, 20, 1, 0, 0, 0, 0, 0, 0);
        chk("full_commit_we", 32'(commit_we_out), 32'd1);
        chk("full_commit_wd", commit_wd_out, 32'hAA);
        chk("full_nobypass", 32'(alloc_ready_out), 32'd0);
        nx(1, 21, 1, 0, 0, 0, 0, 0, 0);
        chk("wrap_ready", 32'(alloc_ready_out), 32'd1);
        chk("wrap_count", 32'(count_out), 32'd7);
        chk("wrap_aix", 32'(alloc_ix_out), 32'd0);
        chk("wrap_cix", 32'(commit_ix_out), 32'd1);
        nx(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_full", 32'(count_out), 32'd8);

        // Randomized run against the reference model.
        do_reset();
        mq.delete();
        mhead  = 0;
        mflush = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst_n_in           = ($urandom_range(0, 299) != 0);
            alloc_valid_in     = ($urandom_range(0, 9) < 6);
            alloc_rd_in        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alloc_writes_rd_in = ($urandom_range(0, 3) != 0);
            alloc_is_branch_in = ($urandom_range(0, 3) == 0);
            cdb_valid_in       = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cdb_ix_in = mq[$urandom_range(0, mq.size() - 1)].ix;
            else
                cdb_ix_in = 3'($urandom);
            cdb_data_in       = $urandom;
            cdb_mispredict_in = ($urandom_range(0, 5) == 0);
            query_ix1_in      = 3'($urandom);
            query_ix2_in      = ($urandom_range(0, 1) != 0) ? cdb_ix_in : 3'($urandom);
            #1;
            if (!rst_n_in) begin
                mq.delete();
                mhead  = 0;
                mflush = 1'b0;
            end else begin
                model_step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
8-entry circular reorder buffer. It sits between issue/CDB writeback and the architectural register file.
- Allocates a ROB index per issued instruction and captures CDB results.
- Commits in program order, at most one entry per cycle, onto the register file's write port (we/wa/wd/wrob_ix).
- On a committed mispredicted branch, squashes all younger entries and drives the register file's flush/flush_addrs inputs.
- Provides operand-forwarding lookups for in-flight ROB indices.

Parameters:
DEPTH, 8, number of entries; fixed, because ROB indices are 3 bits across the design
DATA_W, 32, result width

Ports:
clk_in  input  1  clock
rst_n_in  input  1  synchronous active-low reset
alloc_valid_in  input  1  issue requests an entry this cycle
alloc_rd_in  input  5  destination register of the issuing instruction
alloc_writes_rd_in  input  1  instruction writes rd
alloc_is_branch_in  input  1  instruction is a branch or jump
alloc_ready_out  output  1  entry available; allocation accepted when valid&&ready
alloc_ix_out  output  3  index that will be allocated (current tail)
cdb_valid_in  input  1  result broadcast valid
cdb_ix_in  input  3  ROB index of the result
cdb_data_in  input  32  result value
cdb_mispredict_in  input  1  branch resolved mispredicted
query_ix1_in  input  3  ROB index looked up for operand 1
query_ix2_in  input  3  ROB index looked up for operand 2
query_done1_out  output  1  entry at query_ix1_in is valid and has a result
query_done2_out  output  1  entry at query_ix2_in is valid and has a result
query_data1_out  output  32  result for query 1
query_data2_out  output  32  result for query 2
commit_we_out  output  1  register file write enable
commit_wa_out  output  5  register file write address
commit_wd_out  output  32  register file write data
commit_ix_out  output  3  ROB index being committed (drives wrob_ix)
flush_out  output  1  squash pulse to the register file
flush_addrs_out  output  5x8  unpacked [7:0]; rd of each squashed entry, 0 if unused
count_out  output  4  occupied entries, 0..8
empty_out  output  1  count_out==0

Behaviour:
- State per entry: valid, done, rd, writes_rd, is_branch, mispredict, data.
  - Global state: head[2:0], tail[2:0], count[3:0], flush_q, flush_addrs_q.
- Reset (rst_n_in low at a clock edge):
  - All valid/done cleared; head=tail=0; count=0; flush_q=0; flush_addrs_q all 0.
  - Outputs after reset: commit_we_out=0, flush_out=0, alloc_ready_out=1, empty_out=1, count_out=0, query_done*=0.
  - Reset applied mid-operation discards all entries and any pending flush at that edge.
- Commit eligibility: commit_fire = head entry valid && done && !flush_q.
- Commit outputs are combinational from the head entry.
  - commit_we_out = commit_fire && writes_rd && rd!=0.
  - commit_wa_out = head rd; commit_wd_out = head data; commit_ix_out = head.
- On commit_fire: head entry invalidated; head=head+1 mod 8; count decrements.
- Allocation:
  - alloc_ready_out = count<8 && !flush_q && !(commit_fire && head mispredict). There is no same-cycle bypass of a freeing commit when full.
  - On accept: entry[tail] written with valid=1, done=0, mispredict=0 and the rd/writes_rd/is_branch fields; tail=tail+1 mod 8.
  - Accept and commit in the same cycle leave count unchanged.
- CDB writeback:
  - If cdb_valid_in and entry[cdb_ix_in] is valid: set done=1, store data, mispredict=cdb_mispredict_in && is_branch.
  - A CDB write to an invalid entry is ignored.
  - A CDB write to the head is not committed in the same cycle; earliest commit is the next cycle, i.e. one-cycle result-to-commit latency.
- Query:
  - Combinational: done = entry valid && done; data = entry data.
  - Same-cycle CDB bypass: if cdb_valid_in and cdb_ix_in equals the query index and the entry is valid, then done=1 and data=cdb_data_in.
- Mispredict flush (commit_fire with head mispredict=1, cycle C):
  - The head commits normally in C; a jump's link write occurs.
  - At the edge ending C:
    - flush_addrs_q[j] = rd of entry j if entry j is valid, j!=head and writes_rd, else 0.
    - All entries invalidated; head=tail=0; count=0; flush_q=1.
  - Cycle C+1: flush_out=1; flush_addrs_out=flush_addrs_q; commit_we_out=0; alloc_ready_out=0; CDB writes are ignored because all entries are invalid.
  - flush_q clears at the end of C+1, so flush_out is exactly one cycle wide.
- Register file priority: the register file gives flush priority over writes. The flush cycle therefore never carries a commit write.
- Wrap-around: head and tail are 3-bit and wrap naturally. Full versus empty is distinguished only by count.

Test Plan:
- Reset: rst_n_in=0 for 2 cycles with alloc_valid_in=1 -> count_out=0, alloc_ready_out=1, commit_we_out=0, flush_out=0, alloc_ix_out=0.
- In-order commit: allocate rd=5, then rd=6 (ix 0, 1); CDB ix1 data=0xB first, then ix0 data=0xA next cycle -> commits are (wa=5, wd=0xA, ix=0) and then (wa=6, wd=0xB, ix=1) on consecutive cycles, each one cycle after its result is available.
- Full and wrap: allocate 8 entries -> alloc_ready_out=0, count_out=8. Complete and commit one entry -> ready returns the next cycle and alloc_ix_out wraps to 0.
- rd=0 and non-writing entries: allocate rd=0 with writes_rd=1, then a store (writes_rd=0) -> both commit with commit_we_out=0 while head advances.
- Mispredict: allocate branch (ix0), rd=3 (ix1), rd=7 (ix2); CDB ix0 mispredict=1 -> branch commits, next cycle flush_out=1 with flush_addrs_out={0,3,7,0,0,0,0,0} for entries 0..7, then count_out=0 and alloc_ix_out=0.
- Query bypass: allocate ix2, query_ix1_in=2 -> done=0. CDB ix2 data=0x55 that cycle -> query_done1_out=1 with data=0x55 combinationally; the next cycle still reports 1/0x55 from stored state.
